// File: rtl/lcd_frame_sequencer_if.sv
// rtl/lcd_frame_sequencer_if.sv - start/done handshake between the frame sequencer and the character-LCD driver
interface lcd_frame_sequencer_if;
  logic       lcd_start;
  logic [7:0] lcd_data;
  logic       lcd_loc_req;
  logic       lcd_done;

  modport master (output lcd_start, output lcd_data, output lcd_loc_req, input lcd_done);
  modport slave  (input lcd_start, input lcd_data, input lcd_loc_req, output lcd_done);
endinterface

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - writes "@Ahh Bhh Phh Ohh" to LCD row 2 on request or refresh,
// interleaving single host characters one transaction at a time
module lcd_frame_sequencer #(
  parameter int INIT_CYCLES    = 4600,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int DONE_TIMEOUT   = 4000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [7:0]                   i_reg_a,
  input  logic [7:0]                   i_reg_b,
  input  logic [7:0]                   i_reg_pc,
  input  logic [7:0]                   i_reg_out,
  input  logic                         i_update_req,
  input  logic                         i_host_req,
  input  logic [7:0]                   i_host_data,
  output logic                         o_host_ack,
  output logic                         o_busy,
  output logic                         o_err,
  lcd_frame_sequencer_if.master        lcd
);

  localparam int INIT_W = (INIT_CYCLES > 1)    ? $clog2(INIT_CYCLES)    : 1;
  localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TO_W   = (DONE_TIMEOUT > 1)   ? $clog2(DONE_TIMEOUT)   : 1;

  typedef enum logic [1:0] {S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

  state_t            r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [REF_W-1:0]  r_ref_cnt;
  logic [TO_W-1:0]   r_wait;
  logic [3:0]        r_idx;
  logic [7:0]        r_a, r_b, r_pc, r_out;
  logic [7:0]        r_data;
  logic              r_loc, r_start, r_ack, r_busy, r_err;
  logic              r_pend, r_host, r_done_d;

  logic w_refresh_tick, w_frame_due, w_done_rise;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character for a frame position; position 0 is the '@' written via the DDRAM 0x40 address request.
  function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [7:0] a, b, pc, o);
    logic [7:0] c;
    c = 8'h20;
    case (idx)
      4'd0:  c = 8'h40;
      4'd1:  c = 8'h41;
      4'd2:  c = hex_char(a[7:4]);
      4'd3:  c = hex_char(a[3:0]);
      4'd5:  c = 8'h42;
      4'd6:  c = hex_char(b[7:4]);
      4'd7:  c = hex_char(b[3:0]);
      4'd9:  c = 8'h50;
      4'd10: c = hex_char(pc[7:4]);
      4'd11: c = hex_char(pc[3:0]);
      4'd13: c = 8'h4F;
      4'd14: c = hex_char(o[7:4]);
      4'd15: c = hex_char(o[3:0]);
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  assign w_refresh_tick = (REFRESH_CYCLES != 0) && (r_state != S_INIT_WAIT) &&
                          (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1));
  assign w_frame_due    = r_pend | i_update_req | w_refresh_tick;
  assign w_done_rise    = lcd.lcd_done & ~r_done_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_INIT_WAIT;
      r_init_cnt <= '0;
      r_ref_cnt  <= '0;
      r_wait     <= '0;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_pc       <= '0;
      r_out      <= '0;
      r_data     <= '0;
      r_loc      <= 1'b0;
      r_start    <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_pend     <= 1'b0;
      r_host     <= 1'b0;
      r_done_d   <= 1'b0;
    end else begin
      r_done_d <= lcd.lcd_done;
      r_start  <= 1'b0;
      r_ack    <= 1'b0;
      if (r_state != S_INIT_WAIT)
        r_ref_cnt <= w_refresh_tick ? '0 : r_ref_cnt + 1'b1;
      // Requests merge into a single queued frame; cleared below when a frame is granted.
      if (i_update_req || w_refresh_tick)
        r_pend <= 1'b1;

      case (r_state)
        S_INIT_WAIT: begin
          if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_frame_due) begin
            r_a     <= i_reg_a;
            r_b     <= i_reg_b;
            r_pc    <= i_reg_pc;
            r_out   <= i_reg_out;
            r_idx   <= '0;
            r_host  <= 1'b0;
            r_data  <= 8'h40;
            r_loc   <= 1'b1;
            r_pend  <= 1'b0;
            r_start <= 1'b1;
            r_wait  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end else if (i_host_req) begin
            r_host  <= 1'b1;
            r_data  <= i_host_data;
            r_loc   <= 1'b0;
            r_start <= 1'b1;
            r_wait  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait  <= r_wait + 1'b1;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_done_rise) begin
            if (r_host) begin
              r_ack   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_idx == 4'd15) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_data  <= frame_char(r_idx + 4'd1, r_a, r_b, r_pc, r_out);
              r_loc   <= 1'b0;
              r_start <= 1'b1;
              r_wait  <= '0;
              r_state <= S_ISSUE;
            end
          end else if (r_wait == TO_W'(DONE_TIMEOUT - 1)) begin
            // Abandon the transaction; any queued frame request survives the abort.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lcd.lcd_start   = r_start;
  assign lcd.lcd_data    = r_data;
  assign lcd.lcd_loc_req = r_loc;
  assign o_host_ack      = r_ack;
  assign o_busy          = r_busy;
  assign o_err           = r_err;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - scoreboard bench for lcd_frame_sequencer with a model LCD driver
module tb_lcd_frame_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, rst2;
  logic [7:0] reg_a, reg_b, reg_pc, reg_out;
  logic [7:0] reg2_a, reg2_b, reg2_pc, reg2_out;
  logic       update_req, host_req;
  logic [7:0] host_data;
  logic       host_ack, busy, err;
  logic       host_ack2, busy2, err2;
  logic       zero1;
  logic [7:0] zero8;

  lcd_frame_sequencer_if if1 ();
  lcd_frame_sequencer_if if2 ();

  lcd_frame_sequencer #(.INIT_CYCLES(20), .REFRESH_CYCLES(0), .DONE_TIMEOUT(50)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_reg_a(reg_a), .i_reg_b(reg_b), .i_reg_pc(reg_pc),
    .i_reg_out(reg_out), .i_update_req(update_req), .i_host_req(host_req),
    .i_host_data(host_data), .o_host_ack(host_ack), .o_busy(busy), .o_err(err), .lcd(if1)
  );

  lcd_frame_sequencer #(.INIT_CYCLES(20), .REFRESH_CYCLES(300), .DONE_TIMEOUT(50)) u_dut_ref (
    .i_clk(clk), .i_rst(rst2), .i_reg_a(reg2_a), .i_reg_b(reg2_b), .i_reg_pc(reg2_pc),
    .i_reg_out(reg2_out), .i_update_req(zero1), .i_host_req(zero1),
    .i_host_data(zero8), .o_host_ack(host_ack2), .o_busy(busy2), .o_err(err2), .lcd(if2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [8:0] sb1 [$];
  logic [8:0] sb2 [$];
  int         fstart2 [$];

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
  endfunction

  task automatic push_frame(input bit which, input logic [7:0] a, b, pc, o);
    logic [7:0] c [0:14];
    c = '{8'h41, hx(a[7:4]), hx(a[3:0]), 8'h20, 8'h42, hx(b[7:4]), hx(b[3:0]), 8'h20,
          8'h50, hx(pc[7:4]), hx(pc[3:0]), 8'h20, 8'h4F, hx(o[7:4]), hx(o[3:0])};
    if (which) sb2.push_back({1'b1, 8'h40}); else sb1.push_back({1'b1, 8'h40});
    foreach (c[i]) begin
      if (which) sb2.push_back({1'b0, c[i]}); else sb1.push_back({1'b0, c[i]});
    end
  endtask

  // Driver model 1: done one cycle wide, 5 cycles after start; can be muted.
  bit drv_en = 1'b1;
  int d1_dly = 0, d1_hold = 0, start1_cnt = 0, first_start1 = -1, ack1_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      d1_dly = 0; d1_hold = 0; if1.lcd_done = 1'b0;
    end else begin
      if (host_ack) ack1_cnt++;
      if (d1_hold > 0) begin
        d1_hold--;
        if (d1_hold == 0) if1.lcd_done = 1'b0;
      end else if (d1_dly > 0) begin
        d1_dly--;
        if (d1_dly == 0) begin if1.lcd_done = 1'b1; d1_hold = 1; end
      end
      if (if1.lcd_start) begin
        start1_cnt++;
        if (first_start1 < 0) first_start1 = cyc;
        check_eq("sb1_avail", sb1.size() > 0, 1);
        if (sb1.size() > 0) check_eq("txn1", {if1.lcd_loc_req, if1.lcd_data}, sb1.pop_front());
        if (drv_en) d1_dly = 5;
      end
    end
  end

  // Driver model 2: done held 10 cycles, next rise only after it has dropped.
  int  d2_dly = 0, d2_hold = 0;
  bit  d2_owed = 1'b0;
  always @(negedge clk) begin
    if (rst2) begin
      d2_dly = 0; d2_hold = 0; d2_owed = 1'b0; if2.lcd_done = 1'b0;
    end else begin
      if (d2_hold > 0) begin
        d2_hold--;
        if (d2_hold == 0) if2.lcd_done = 1'b0;
      end else if (d2_dly > 0) begin
        d2_dly--;
        if (d2_dly == 0) begin if2.lcd_done = 1'b1; d2_hold = 10; d2_owed = 1'b0; end
      end
      if (if2.lcd_start) begin
        check_eq("start2_after_done", d2_owed, 0);
        d2_owed = 1'b1;
        if (if2.lcd_loc_req && if2.lcd_data == 8'h40) fstart2.push_back(cyc);
        check_eq("sb2_avail", sb2.size() > 0, 1);
        if (sb2.size() > 0) check_eq("txn2", {if2.lcd_loc_req, if2.lcd_data}, sb2.pop_front());
        d2_dly = 5;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
  endtask

  task automatic wait_idle1(input int budget, input string tag);
    int k;
    k = 0;
    while (!(sb1.size() == 0 && !busy && !host_req) && k < budget) begin
      tick();
      if (host_ack) host_req = 1'b0;
      k++;
    end
    check_eq(tag, k < budget, 1);
  endtask

  initial begin
    int base, rel, s0, k;
    string s;
    rst = 1'b1; rst2 = 1'b1; zero1 = 1'b0; zero8 = 8'h00;
    update_req = 1'b0; host_req = 1'b0; host_data = 8'h00;
    reg_a = 8'h00; reg_b = 8'h00; reg_pc = 8'h00; reg_out = 8'h00;
    reg2_a = 8'h12; reg2_b = 8'hEF; reg2_pc = 8'h09; reg2_out = 8'hB0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ack", host_ack, 0);
    check_eq("rst_start", if1.lcd_start, 0);
    check_eq("rst_data", if1.lcd_data, 0);
    check_eq("rst_loc", if1.lcd_loc_req, 0);

    // T1/T2: request latched during init, first transaction only after init
    rst = 1'b0;
    rel = cyc;
    first_start1 = -1;
    repeat (2) tick();
    reg_a = 8'h3F; reg_b = 8'h00; reg_pc = 8'h1C; reg_out = 8'hA7;
    s = "A3F B00 P1C OA7";
    sb1.push_back({1'b1, 8'h40});
    for (int i = 0; i < 15; i++) sb1.push_back({1'b0, s[i]});
    pulse_update();
    base = start1_cnt;
    wait_idle1(600, "t2_frame_done");
    check_eq("t1_no_early_start", (first_start1 - rel) >= 20, 1);
    check_eq("t1_start_soon", (first_start1 - rel) <= 22, 1);
    check_eq("t2_txn_count", start1_cnt - base, 16);

    // T3: snapshot holds mid-frame; two mid-frame requests merge into one frame
    base = start1_cnt;
    push_frame(0, 8'h3F, 8'h00, 8'h1C, 8'hA7);
    push_frame(0, 8'h55, 8'h00, 8'h1C, 8'hA7);
    pulse_update();
    k = 0;
    while (start1_cnt < base + 3 && k < 100) begin tick(); k++; end
    check_eq("t3_mid_reached", k < 100, 1);
    reg_a = 8'h55;
    pulse_update();
    tick();
    pulse_update();
    wait_idle1(1200, "t3_frames_done");
    repeat (30) tick();
    check_eq("t3_txn_count", start1_cnt - base, 32);

    // T4: frame and host in the same cycle; frame goes first, then one host char
    base = ack1_cnt;
    push_frame(0, 8'h55, 8'h00, 8'h1C, 8'hA7);
    sb1.push_back({1'b0, 8'h48});
    host_data = 8'h48;
    host_req = 1'b1;
    pulse_update();
    wait_idle1(800, "t4_done");
    repeat (10) tick();
    check_eq("t4_ack_count", ack1_cnt - base, 1);
    check_eq("t4_err_clear", err, 0);

    // T5: driver silent, timeout after 50 cycles
    drv_en = 1'b0;
    base = start1_cnt;
    sb1.push_back({1'b1, 8'h40});
    pulse_update();
    k = 0;
    while (start1_cnt == base && k < 20) begin tick(); k++; end
    check_eq("t5_start_seen", k < 20, 1);
    repeat (49) tick();
    check_eq("t5_err_before", err, 0);
    tick();
    check_eq("t5_err_at_timeout", err, 1);
    tick();
    check_eq("t5_busy_after", busy, 0);
    repeat (20) tick();
    check_eq("t5_err_sticky", err, 1);
    check_eq("t5_no_retry", start1_cnt - base, 1);
    drv_en = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    check_eq("t5_err_rst", err, 0);

    // T6: periodic refresh on the second instance, done held high
    push_frame(1, 8'h12, 8'hEF, 8'h09, 8'hB0);
    push_frame(1, 8'h12, 8'hEF, 8'h09, 8'hB0);
    push_frame(1, 8'h12, 8'hEF, 8'h09, 8'hB0);
    rst2 = 1'b0;
    rel = cyc;
    k = 0;
    while (!(sb2.size() == 0 && !busy2) && k < 1500) begin tick(); k++; end
    check_eq("t6_frames_done", k < 1500, 1);
    rst2 = 1'b1;
    tick();
    check_eq("t6_frame_count", fstart2.size(), 3);
    if (fstart2.size() == 3) begin
      check_eq("t6_first_frame", fstart2[0] - rel, 320);
      check_eq("t6_period_1", fstart2[1] - fstart2[0], 300);
      check_eq("t6_period_2", fstart2[2] - fstart2[1], 300);
    end
    check_eq("t6_err2", err2, 0);
    s0 = n_checks;
    check_eq("bench_ran", s0 > 12, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
